// File: rtl/approx_mul_err_sweeper_if.sv
// Bundle of control, multiplier-bus and result signals for the
// approximate-multiplier error sweeper.
interface approx_mul_err_sweeper_if #(
  parameter int W    = 8,
  parameter int SUMW = 32
);
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [2*W-1:0]   mul_p;
  logic [SUMW-1:0]  sum_abs_err;
  logic [2*W-1:0]   max_err;
  logic [W-1:0]     max_a;
  logic [W-1:0]     max_b;
  logic [2*W:0]     err_cnt;

  // Sweeper side: drives operands and results, receives product and control.
  modport master (
    input  start, abort, mul_p,
    output busy, done, mul_a, mul_b, sum_abs_err, max_err, max_a, max_b, err_cnt
  );

  // Harness side: drives control and the multiplier product, observes the rest.
  modport slave (
    output start, abort, mul_p,
    input  busy, done, mul_a, mul_b, sum_abs_err, max_err, max_a, max_b, err_cnt
  );
endinterface

// File: rtl/approx_mul_err_sweeper.sv
// Exhaustive error-characterisation sequencer for a WxW approximate multiplier.
// Walks every operand pair (A fastest), compares the returned product with the
// exact product two cycles later, and accumulates sum/max/count of errors.
module approx_mul_err_sweeper #(
  parameter int W    = 8,
  parameter int SUMW = 32
) (
  input logic                     clk,
  input logic                     rst_n,
  approx_mul_err_sweeper_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2*W-1:0] IDX_LAST = {(2*W){1'b1}};

  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic            busy_r;
  logic            done_r;

  // idx doubles as the registered operand pair {mul_b, mul_a}
  logic [2*W-1:0]  idx_r;

  // stage 1: operands and returned product captured together
  logic [W-1:0]    a1_r;
  logic [W-1:0]    b1_r;
  logic [2*W-1:0]  p1_r;
  logic            v1_r;

  // results
  logic [SUMW-1:0] sum_r;
  logic [2*W-1:0]  max_err_r;
  logic [W-1:0]    max_a_r;
  logic [W-1:0]    max_b_r;
  logic [2*W:0]    err_cnt_r;

  logic            start_take_s;
  logic            abort_take_s;
  logic            sweep_step_s;
  logic [2*W-1:0]  prod_s;
  logic [2*W-1:0]  err_s;
  logic [SUMW:0]   sum_ext_s;
  logic [SUMW-1:0] sum_nxt_s;

  // Qualify start/abort by state; abort dominates start in IDLE.
  always_comb begin
    start_take_s = (state_r == S_IDLE) && bus.start && !bus.abort;
    abort_take_s = bus.abort && ((state_r == S_SWEEP) || (state_r == S_DRAIN));
    sweep_step_s = (state_r == S_SWEEP) && !bus.abort;
  end

  // Next-state logic for IDLE -> SWEEP -> DRAIN -> DONE -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_take_s) state_nxt_s = S_SWEEP;
        else              state_nxt_s = S_IDLE;
      end
      S_SWEEP: begin
        if (abort_take_s)            state_nxt_s = S_IDLE;
        else if (idx_r == IDX_LAST)  state_nxt_s = S_DRAIN;
        else                         state_nxt_s = S_SWEEP;
      end
      S_DRAIN: begin
        if (abort_take_s) state_nxt_s = S_IDLE;
        else              state_nxt_s = S_DONE;
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Stage-2 datapath: absolute error against the exact product, saturating sum.
  always_comb begin
    prod_s = {{W{1'b0}}, a1_r} * {{W{1'b0}}, b1_r};
    if (p1_r >= prod_s) err_s = p1_r - prod_s;
    else                err_s = prod_s - p1_r;
    sum_ext_s = {1'b0, sum_r} + {{(SUMW + 1 - 2*W){1'b0}}, err_s};
    if (sum_ext_s[SUMW]) sum_nxt_s = {SUMW{1'b1}};
    else                 sum_nxt_s = sum_ext_s[SUMW-1:0];
  end

  // State register with busy/done decoded from the next state so both are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == S_SWEEP) || (state_nxt_s == S_DRAIN);
      done_r  <= (state_nxt_s == S_DONE);
    end
  end

  // Operand index: cleared on start, advances in SWEEP, parks on the last pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= {(2*W){1'b0}};
    end else if (start_take_s) begin
      idx_r <= {(2*W){1'b0}};
    end else if (sweep_step_s && (idx_r != IDX_LAST)) begin
      idx_r <= idx_r + {{(2*W-1){1'b0}}, 1'b1};
    end else begin
      idx_r <= idx_r;
    end
  end

  // Stage 1: capture the pair on the bus and its returned product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_r <= {W{1'b0}};
      b1_r <= {W{1'b0}};
      p1_r <= {(2*W){1'b0}};
      v1_r <= 1'b0;
    end else if (sweep_step_s) begin
      a1_r <= idx_r[W-1:0];
      b1_r <= idx_r[2*W-1:W];
      p1_r <= bus.mul_p;
      v1_r <= 1'b1;
    end else begin
      v1_r <= 1'b0;
    end
  end

  // Stage 2: accumulate; strict compare keeps the earliest pair on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r     <= {SUMW{1'b0}};
      max_err_r <= {(2*W){1'b0}};
      max_a_r   <= {W{1'b0}};
      max_b_r   <= {W{1'b0}};
      err_cnt_r <= {(2*W+1){1'b0}};
    end else if (start_take_s) begin
      sum_r     <= {SUMW{1'b0}};
      max_err_r <= {(2*W){1'b0}};
      max_a_r   <= {W{1'b0}};
      max_b_r   <= {W{1'b0}};
      err_cnt_r <= {(2*W+1){1'b0}};
    end else if (v1_r && !abort_take_s) begin
      sum_r <= sum_nxt_s;
      if (err_s != {(2*W){1'b0}}) err_cnt_r <= err_cnt_r + {{(2*W){1'b0}}, 1'b1};
      else                        err_cnt_r <= err_cnt_r;
      if (err_s > max_err_r) begin
        max_err_r <= err_s;
        max_a_r   <= a1_r;
        max_b_r   <= b1_r;
      end else begin
        max_err_r <= max_err_r;
        max_a_r   <= max_a_r;
        max_b_r   <= max_b_r;
      end
    end else begin
      sum_r <= sum_r;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.mul_a       = idx_r[W-1:0];
  assign bus.mul_b       = idx_r[2*W-1:W];
  assign bus.sum_abs_err = sum_r;
  assign bus.max_err     = max_err_r;
  assign bus.max_a       = max_a_r;
  assign bus.max_b       = max_b_r;
  assign bus.err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_approx_mul_err_sweeper.sv
// Directed bench: a W=2 (SUMW=6) sweeper driven by selectable multiplier stubs,
// plus one full W=8 sweep with a product that is always off by one.
module tb_approx_mul_err_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   mode = 0;

  always #5 clk = ~clk;

  approx_mul_err_sweeper_if #(.W(2), .SUMW(6))  if2 ();
  approx_mul_err_sweeper_if #(.W(8), .SUMW(32)) if8 ();

  approx_mul_err_sweeper #(.W(2), .SUMW(6))  dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));
  approx_mul_err_sweeper #(.W(8), .SUMW(32)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.master));

  // W=2 multiplier stubs: 0 zero, 1 exact, 2 exact^1, 3 all ones, 4 constant 4
  always_comb begin
    case (mode)
      0: if2.mul_p = 4'd0;
      1: if2.mul_p = {2'b00, if2.mul_a} * {2'b00, if2.mul_b};
      2: if2.mul_p = ({2'b00, if2.mul_a} * {2'b00, if2.mul_b}) ^ 4'd1;
      3: if2.mul_p = 4'hF;
      4: if2.mul_p = 4'd4;
      default: if2.mul_p = 4'd0;
    endcase
  end

  // W=8 stub: exact product with the LSB flipped
  always_comb if8.mul_p = ({8'd0, if8.mul_a} * {8'd0, if8.mul_b}) ^ 16'd1;

  typedef struct {
    int         mode;
    logic [5:0] sum;
    logic [3:0] mx;
    logic [1:0] ma;
    logic [1:0] mb;
    logic [4:0] cnt;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Caller is positioned 1 time unit after a rising edge.
  task automatic run2(input vec_t v, input bit noisy, input string tag);
    int cyc;
    int nbusy;
    bit seen;
    mode = v.mode;
    if2.start = 1'b1;
    @(posedge clk); #1;
    if (!noisy) if2.start = 1'b0;
    cyc = 0; nbusy = 0; seen = 1'b0;
    while (!seen && cyc <= 40) begin
      if (if2.done) seen = 1'b1;
      else begin
        if (if2.busy) nbusy++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk({tag, ".done_seen"}, 64'(seen), 64'd1);
    chk({tag, ".done_latency"}, 64'(cyc), 64'd17);
    chk({tag, ".busy_cycles"}, 64'(nbusy), 64'd17);
    chk({tag, ".busy_in_done"}, 64'(if2.busy), 64'd0);
    chk({tag, ".sum"}, 64'(if2.sum_abs_err), 64'(v.sum));
    chk({tag, ".max_err"}, 64'(if2.max_err), 64'(v.mx));
    chk({tag, ".max_a"}, 64'(if2.max_a), 64'(v.ma));
    chk({tag, ".max_b"}, 64'(if2.max_b), 64'(v.mb));
    chk({tag, ".err_cnt"}, 64'(if2.err_cnt), 64'(v.cnt));
    @(posedge clk); #1;
    if2.start = 1'b0;
    chk({tag, ".done_one_cycle"}, 64'(if2.done), 64'd0);
    nbusy = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (if2.busy || if2.done) nbusy++;
    end
    chk({tag, ".stays_idle"}, 64'(nbusy), 64'd0);
    chk({tag, ".sum_hold"}, 64'(if2.sum_abs_err), 64'(v.sum));
  endtask

  initial begin
    int cyc;
    int ndone;
    bit seen;

    tbl[0] = '{mode: 0, sum: 6'd36, mx: 4'd9,  ma: 2'd3, mb: 2'd3, cnt: 5'd9};
    tbl[1] = '{mode: 1, sum: 6'd0,  mx: 4'd0,  ma: 2'd0, mb: 2'd0, cnt: 5'd0};
    tbl[2] = '{mode: 2, sum: 6'd16, mx: 4'd1,  ma: 2'd0, mb: 2'd0, cnt: 5'd16};
    tbl[3] = '{mode: 3, sum: 6'd63, mx: 4'd15, ma: 2'd0, mb: 2'd0, cnt: 5'd16};
    tbl[4] = '{mode: 4, sum: 6'd46, mx: 4'd5,  ma: 2'd3, mb: 2'd3, cnt: 5'd15};

    if2.start = 1'b0; if2.abort = 1'b0;
    if8.start = 1'b0; if8.abort = 1'b0;
    #12;
    chk("reset.busy", 64'(if2.busy), 64'd0);
    chk("reset.done", 64'(if2.done), 64'd0);
    chk("reset.sum", 64'(if2.sum_abs_err), 64'd0);
    chk("reset.err_cnt", 64'(if2.err_cnt), 64'd0);
    chk("reset.mul_ab", 64'({if2.mul_b, if2.mul_a}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // table of stub patterns
    for (int i = 0; i < 5; i++) run2(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // start held high through SWEEP, DRAIN and DONE
    run2(tbl[0], 1'b1, "noisy_start");

    // abort together with start in IDLE
    if2.start = 1'b1; if2.abort = 1'b1;
    @(posedge clk); #1;
    chk("abort_start_idle.busy", 64'(if2.busy), 64'd0);
    if2.start = 1'b0; if2.abort = 1'b0;
    @(posedge clk); #1;
    chk("abort_start_idle.busy2", 64'(if2.busy), 64'd0);

    // abort during the 6th SWEEP cycle
    mode = 3;
    if2.start = 1'b1;
    @(posedge clk); #1;
    if2.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    chk("abort.busy_before", 64'(if2.busy), 64'd1);
    if2.abort = 1'b1;
    @(posedge clk); #1;
    if2.abort = 1'b0;
    chk("abort.busy_after", 64'(if2.busy), 64'd0);
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      if (if2.done || if2.busy) ndone++;
      @(posedge clk); #1;
    end
    chk("abort.no_done", 64'(ndone), 64'd0);
    run2(tbl[0], 1'b0, "after_abort");

    // asynchronous reset mid-sweep
    mode = 3;
    if2.start = 1'b1;
    @(posedge clk); #1;
    if2.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid.sum_before", 64'(if2.sum_abs_err != 6'd0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.sum", 64'(if2.sum_abs_err), 64'd0);
    chk("rst_mid.max_err", 64'(if2.max_err), 64'd0);
    chk("rst_mid.err_cnt", 64'(if2.err_cnt), 64'd0);
    chk("rst_mid.mul_ab", 64'({if2.mul_b, if2.mul_a}), 64'd0);
    chk("rst_mid.busy", 64'(if2.busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (if2.done) ndone++;
      @(posedge clk); #1;
    end
    chk("rst_mid.no_done", 64'(ndone), 64'd0);
    run2(tbl[0], 1'b0, "after_reset");

    // full W=8 sweep with every product off by one
    if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc <= 70000) begin
      if (if8.done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("w8.done_seen", 64'(seen), 64'd1);
    chk("w8.done_latency", 64'(cyc), 64'd65537);
    chk("w8.sum", 64'(if8.sum_abs_err), 64'd65536);
    chk("w8.err_cnt", 64'(if8.err_cnt), 64'd65536);
    chk("w8.max_err", 64'(if8.max_err), 64'd1);
    chk("w8.max_ab", 64'({if8.max_b, if8.max_a}), 64'd0);
    chk("w8.mul_ab_hold", 64'({if8.mul_b, if8.mul_a}), 64'hFFFF);
    @(posedge clk); #1;
    chk("w8.done_one_cycle", 64'(if8.done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
